// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweep harnesses.
//   state_t  : sweep controller states (IDLE, HOLD, DONE)
//   tt_width : table width for an n-input gate (2**n)
//   tt_bit   : expected output for input vector i, using the
//              "first vector lands in the MSB" bit ordering
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest table the helper accepts (8-input gates).
    localparam int unsigned TT_MAX_W = 256;

    function automatic int unsigned tt_width(input int unsigned n_inputs);
        return 32'd1 << n_inputs;
    endfunction

    // Table bit (tt_w-1-i) is f(i): vector 0 maps to the MSB.
    function automatic logic tt_bit(input logic [TT_MAX_W-1:0] tt,
                                    input int unsigned         tt_w,
                                    input int unsigned         i);
        logic [7:0] pos;
        pos = 8'(tt_w - 32'd1 - i);
        return tt[pos];
    endfunction

endpackage

// File: rtl/tt_sweep_capture_counter.sv
// Vector index / settle counter for the truth-table sweep.
//   clk, rst     : clock, synchronous active-high reset
//   clear        : restart from vector 0 (start or abort)
//   run          : sweep in progress this cycle
//   idx          : current input vector (drives the gate directly)
//   sample       : this edge captures the gate output for idx
//   last_sample  : sample of the final vector
module tt_vector_counter
    import tt_sweep_pkg::*;
#(
    parameter int unsigned N_INPUTS      = 4,
    parameter int unsigned SETTLE_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                run,
    output logic [N_INPUTS-1:0] idx,
    output logic                sample,
    output logic                last_sample
);

    localparam int unsigned TT_W = tt_width(N_INPUTS);

    logic [N_INPUTS-1:0] idx_reg;
    logic [7:0]          hold_reg;

    // Equality rather than "<" keeps the SETTLE_CYCLES=0 case free of an
    // always-false comparison.
    assign sample      = run && (hold_reg == 8'(SETTLE_CYCLES));
    assign last_sample = sample && (idx_reg == N_INPUTS'(TT_W - 1));
    assign idx         = idx_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx_reg  <= '0;
            hold_reg <= '0;
        end else if (run) begin
            if (!sample) begin
                hold_reg <= hold_reg + 8'd1;
            end else begin
                hold_reg <= '0;
                // After the final vector the gate input returns to 0 rather
                // than sweeping on; the controller leaves HOLD on this edge.
                idx_reg  <= last_sample ? '0 : idx_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tt_sweep_capture.sv
// Exhaustive truth-table sweep and capture around an N-input, 1-output gate.
// Every input vector is driven in turn, the gate output is shifted into a
// table (vector 0 in the MSB) and compared bit-by-bit against EXPECTED_TT.
//   clk, rst       : clock, synchronous active-high reset
//   start          : begin a sweep (accepted only in IDLE)
//   abort          : cancel a sweep in progress (no done, results kept)
//   dut_in         : vector to the gate, MSB = gate input _0
//   dut_out        : gate output
//   busy           : high while vectors are being driven
//   done           : one-cycle pulse when a sweep completes
//   tt_out         : last completed captured table
//   match          : tt_out == EXPECTED_TT
//   mismatch_cnt   : number of table bits that differed
//   first_err_idx  : lowest mismatching vector (0 if none)
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter int unsigned  N_INPUTS      = 4,
    localparam int unsigned TT_W          = 2 ** N_INPUTS,
    parameter logic [TT_W-1:0] EXPECTED_TT = 16'hA2DA,
    parameter int unsigned  SETTLE_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic [N_INPUTS-1:0] dut_in,
    input  logic                dut_out,
    output logic                busy,
    output logic                done,
    output logic [TT_W-1:0]     tt_out,
    output logic                match,
    output logic [N_INPUTS:0]   mismatch_cnt,
    output logic [N_INPUTS-1:0] first_err_idx
);

    state_t state_reg, state_next;

    logic [N_INPUTS-1:0] idx;
    logic                sample;
    logic                last_sample;
    logic                cnt_clear;
    logic                cnt_run;

    logic [TT_W-1:0]     shift_reg, shift_next;
    logic [N_INPUTS:0]   err_cnt_reg, err_cnt_next;
    logic                err_seen_reg;
    logic [N_INPUTS-1:0] first_err_reg, first_err_next;

    logic [TT_MAX_W-1:0] expected_ext;
    logic                exp_bit;
    logic                bit_err;

    logic [TT_W-1:0]     tt_out_reg;
    logic                match_reg;
    logic [N_INPUTS:0]   mismatch_cnt_reg;
    logic [N_INPUTS-1:0] first_err_idx_reg;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = HOLD;
            HOLD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (last_sample) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Abort takes priority over a simultaneous last sample: no done, no
    // result update.
    assign cnt_clear = ((state_reg == IDLE) && start) || ((state_reg == HOLD) && abort);
    assign cnt_run   = (state_reg == HOLD) && !abort;

    tt_vector_counter #(
        .N_INPUTS      (N_INPUTS),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_counter (
        .clk         (clk),
        .rst         (rst),
        .clear       (cnt_clear),
        .run         (cnt_run),
        .idx         (idx),
        .sample      (sample),
        .last_sample (last_sample)
    );

    // ------------------------------------------------------------------
    // Capture and compare
    // ------------------------------------------------------------------
    always_comb begin
        expected_ext             = '0;
        expected_ext[TT_W-1:0]   = EXPECTED_TT;
    end

    assign exp_bit        = tt_bit(expected_ext, TT_W, 32'(idx));
    assign bit_err        = dut_out ^ exp_bit;
    assign shift_next     = {shift_reg[TT_W-2:0], dut_out};
    assign err_cnt_next   = err_cnt_reg + {{N_INPUTS{1'b0}}, bit_err};
    assign first_err_next = (bit_err && !err_seen_reg) ? idx : first_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg         <= '0;
            err_cnt_reg       <= '0;
            err_seen_reg      <= 1'b0;
            first_err_reg     <= '0;
            tt_out_reg        <= '0;
            match_reg         <= 1'b0;
            mismatch_cnt_reg  <= '0;
            first_err_idx_reg <= '0;
        end else if ((state_reg == IDLE) && start) begin
            shift_reg     <= '0;
            err_cnt_reg   <= '0;
            err_seen_reg  <= 1'b0;
            first_err_reg <= '0;
        end else if (cnt_run && sample) begin
            shift_reg     <= shift_next;
            err_cnt_reg   <= err_cnt_next;
            first_err_reg <= first_err_next;
            if (bit_err) begin
                err_seen_reg <= 1'b1;
            end
            // Results are published on the edge that enters DONE, so they
            // are already valid while done is high.
            if (last_sample) begin
                tt_out_reg        <= shift_next;
                match_reg         <= (shift_next == EXPECTED_TT);
                mismatch_cnt_reg  <= err_cnt_next;
                first_err_idx_reg <= first_err_next;
            end
        end
    end

    assign dut_in        = idx;
    assign busy          = (state_reg == HOLD);
    assign done          = (state_reg == DONE);
    assign tt_out        = tt_out_reg;
    assign match         = match_reg;
    assign mismatch_cnt  = mismatch_cnt_reg;
    assign first_err_idx = first_err_idx_reg;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench for tt_sweep_capture: golden and faulty gate models on a
// SETTLE_CYCLES=0 instance, a golden gate on a SETTLE_CYCLES=2 instance.
module tb_tt_sweep_capture;

    localparam logic [15:0] GOLDEN = 16'hA2DA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start0, start2, abort;
    logic [3:0]  dut_in0, dut_in2;
    logic        g0, g2;
    logic        busy0, done0, match0, busy2, done2, match2;
    logic [15:0] tt0, tt2;
    logic [4:0]  cnt0, cnt2;
    logic [3:0]  fe0, fe2;

    // Gate model: 0 golden, 1 stuck-at-0, 2 inverted, 3 wrong at vector 5,
    // 4 wrong at vector 15.
    int mode;
    always_comb begin
        g0 = GOLDEN[4'd15 - dut_in0];
        case (mode)
            1: g0 = 1'b0;
            2: g0 = ~g0;
            3: g0 = g0 ^ (dut_in0 == 4'd5);
            4: g0 = g0 ^ (dut_in0 == 4'd15);
            default: ;
        endcase
    end
    assign g2 = GOLDEN[4'd15 - dut_in2];

    tt_sweep_capture #(.N_INPUTS(4), .EXPECTED_TT(16'hA2DA), .SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort),
        .dut_in(dut_in0), .dut_out(g0), .busy(busy0), .done(done0),
        .tt_out(tt0), .match(match0), .mismatch_cnt(cnt0), .first_err_idx(fe0)
    );

    tt_sweep_capture #(.N_INPUTS(4), .EXPECTED_TT(16'hA2DA), .SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort),
        .dut_in(dut_in2), .dut_out(g2), .busy(busy2), .done(done2),
        .tt_out(tt2), .match(match2), .mismatch_cnt(cnt2), .first_err_idx(fe2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sweep on the SETTLE_CYCLES=0 instance; start is re-pulsed at
    // restart_at (must be ignored). Returns cycles from start edge to done.
    task automatic sweep0(input string tag, input int restart_at, output int cyc);
        cyc = 0;
        while (cyc < 200) begin
            start0 = (cyc == 0) || (cyc == restart_at);
            tick();
            cyc++;
            if (done0) break;
            if (busy0) check({tag, "_dut_in"}, 32'(dut_in0), 32'(cyc - 1));
        end
        start0 = 1'b0;
        if (!done0) check({tag, "_timeout"}, 32'(done0), 32'd1);
        $display("[TB] sweep %s: cycles=%0d tt_out=%h match=%0d mismatch_cnt=%0d first_err_idx=%0d",
                 tag, cyc, tt0, match0, cnt0, fe0);
    endtask

    task automatic expect0(input string tag, input logic [15:0] tt, input logic m,
                           input logic [4:0] cnt, input logic [3:0] fe);
        check({tag, "_tt_out"}, 32'(tt0), 32'(tt));
        check({tag, "_match"}, 32'(match0), 32'(m));
        check({tag, "_mismatch_cnt"}, 32'(cnt0), 32'(cnt));
        check({tag, "_first_err_idx"}, 32'(fe0), 32'(fe));
    endtask

    initial begin
        int cyc;
        int busy_cnt;
        logic saw_done, saw_busy;

        mode   = 0;
        rst    = 1'b1;
        start0 = 1'b0;
        start2 = 1'b0;
        abort  = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_dut_in", 32'(dut_in0), 32'd0);
        expect0("rst", 16'h0000, 1'b0, 5'd0, 4'd0);
        check("rst_tt_out2", 32'(tt2), 32'd0);
        rst = 1'b0;
        tick();

        // Golden sweep
        sweep0("golden", -1, cyc);
        check("golden_latency", 32'(cyc), 32'd17);
        check("golden_busy_at_done", 32'(busy0), 32'd0);
        expect0("golden", 16'hA2DA, 1'b1, 5'd0, 4'd0);
        tick();
        check("golden_done_pulse", 32'(done0), 32'd0);
        check("golden_dut_in_idle", 32'(dut_in0), 32'd0);

        // Stuck-at-0 gate
        mode = 1;
        sweep0("stuck0", -1, cyc);
        expect0("stuck0", 16'h0000, 1'b0, 5'd8, 4'd0);
        tick();

        // Inverted gate: every bit differs
        mode = 2;
        sweep0("invert", -1, cyc);
        expect0("invert", 16'h5D25, 1'b0, 5'd16, 4'd0);
        tick();

        // Single error at vector 5
        mode = 3;
        sweep0("err5", -1, cyc);
        expect0("err5", 16'hA6DA, 1'b0, 5'd1, 4'd5);
        tick();

        // Single error at the last vector
        mode = 4;
        sweep0("err15", -1, cyc);
        expect0("err15", 16'hA2DB, 1'b0, 5'd1, 4'd15);
        tick();

        // Golden sweep with start re-pulsed while busy
        mode = 0;
        sweep0("restart", 5, cyc);
        check("restart_latency", 32'(cyc), 32'd17);
        expect0("restart", 16'hA2DA, 1'b1, 5'd0, 4'd0);
        saw_busy = 1'b0;
        repeat (5) begin
            tick();
            saw_busy |= busy0;
        end
        check("restart_not_queued", 32'(saw_busy), 32'd0);

        // Abort in the 5th busy cycle
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_dut_in", 32'(dut_in0), 32'd0);
        saw_done = 1'b0;
        saw_busy = 1'b0;
        repeat (20) begin
            saw_done |= done0;
            saw_busy |= busy0;
            tick();
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        check("abort_no_busy", 32'(saw_busy), 32'd0);
        expect0("abort", 16'hA2DA, 1'b1, 5'd0, 4'd0);
        $display("[TB] abort: busy=%0d tt_out=%h match=%0d", busy0, tt0, match0);

        // SETTLE_CYCLES=2 instance
        cyc = 0;
        busy_cnt = 0;
        while (cyc < 300) begin
            start2 = (cyc == 0);
            tick();
            cyc++;
            if (done2) break;
            if (busy2) begin
                busy_cnt++;
                check("settle2_dut_in", 32'(dut_in2), 32'((cyc - 1) / 3));
            end
        end
        start2 = 1'b0;
        check("settle2_done", 32'(done2), 32'd1);
        check("settle2_latency", 32'(cyc), 32'd49);
        check("settle2_busy_cycles", 32'(busy_cnt), 32'd48);
        check("settle2_tt_out", 32'(tt2), 32'hA2DA);
        check("settle2_match", 32'(match2), 32'd1);
        check("settle2_mismatch_cnt", 32'(cnt2), 32'd0);
        $display("[TB] sweep settle2: cycles=%0d busy=%0d tt_out=%h match=%0d",
                 cyc, busy_cnt, tt2, match2);
        tick();

        // Reset in the middle of a sweep
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_done", 32'(done0), 32'd0);
        check("midrst_dut_in", 32'(dut_in0), 32'd0);
        expect0("midrst", 16'h0000, 1'b0, 5'd0, 4'd0);
        check("midrst_tt_out2", 32'(tt2), 32'd0);
        $display("[TB] reset mid-sweep: busy=%0d tt_out=%h", busy0, tt0);
        tick();

        sweep0("after_rst", -1, cyc);
        check("after_rst_latency", 32'(cyc), 32'd17);
        expect0("after_rst", 16'hA2DA, 1'b1, 5'd0, 4'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_sweep_capture.md
Name: tt_sweep_capture

Overview:
- Exhaustive truth-table stimulus and capture stage that sits directly around a synthesized N-input gate netlist (4-input, single-output, e.g. function 0xA2DA).
- Drives every input combination into the gate, samples the gate output, and assembles the captured truth table.
- Compares the captured table against an expected constant.
- Used as the bench-side and silicon-side harness for checking synthesized designs against their target hex truth table.

Parameters:
- N_INPUTS, 4, number of gate inputs; table width TT_W = 2**N_INPUTS.
- EXPECTED_TT, 16'hA2DA, expected truth table, TT_W bits.
- SETTLE_CYCLES, 0, extra cycles each vector is held before sampling; range 0..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; accepted only in IDLE.
- abort  in  1  synchronous cancel of a sweep in progress.
- dut_in  out  N_INPUTS  vector to gate; dut_in[N_INPUTS-1] drives gate input _0 (MSB), dut_in[0] drives the highest-numbered input.
- dut_out  in  1  gate output.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse when a sweep completes.
- tt_out  out  TT_W  last completed captured table.
- match  out  1  tt_out == EXPECTED_TT; valid from done onward.
- mismatch_cnt  out  N_INPUTS+1  number of differing table bits.
- first_err_idx  out  N_INPUTS  lowest vector index i that mismatched; 0 if none.

Behaviour:
- Bit convention: tt bit (TT_W-1-i) = f(i), where i = dut_in value. First sample lands in the MSB.
- Check: the 0xA2DA netlist yields f(0)=1, f(1)=0, f(2)=1, f(3)=0, reading 1010_0010_1101_1010.
- Reset value of all outputs and internal state is 0, state IDLE. Reset overrides start and abort in the same cycle.
- FSM states: IDLE, HOLD, DONE.
- IDLE:
  - On start: idx<=0, dut_in<=0, hold_cnt<=0, shift<=0, err counters<=0; go to HOLD; busy=1 from the next cycle.
- HOLD:
  - dut_in = idx. When hold_cnt < SETTLE_CYCLES, increment hold_cnt.
  - Otherwise sample at this edge: shift <= {shift[TT_W-2:0], dut_out}.
  - Compare dut_out against EXPECTED_TT[TT_W-1-idx]. On the first difference, latch first_err_idx = idx and increment mismatch accumulator.
  - After sampling, hold_cnt<=0. If idx == TT_W-1, go to DONE; else idx<=idx+1 and dut_in<=idx+1. No wrap beyond TT_W-1.
  - Each vector is held exactly SETTLE_CYCLES+1 cycles. busy is high for TT_W*(SETTLE_CYCLES+1) cycles.
- DONE (one cycle):
  - done=1, busy=0; tt_out, match, mismatch_cnt, first_err_idx updated at entry; dut_in<=0; return to IDLE.
- start in HOLD or DONE is ignored (not queued).
- Result outputs hold their value until the next completed sweep.
- abort in HOLD: next cycle IDLE, busy=0, dut_in=0, no done; results keep the previous sweep's values.
- abort in IDLE/DONE: no effect. abort and start in the same IDLE cycle: start wins.
- rst mid-sweep: all state and results cleared to 0 at once.
- mismatch_cnt saturates naturally; max TT_W fits in N_INPUTS+1 bits.

Decomposition:
- Shared package tt_sweep_pkg holds:
  - state enum {IDLE, HOLD, DONE};
  - the TT_W derivation;
  - a function tt_bit(tt, i) returning tt[TT_W-1-i], reused by the other truth-table harnesses.
- One sub-module, tt_vector_counter: idx/hold_cnt counters with a last_sample flag. The FSM, shift register and comparator stay in the top.

Test Plan:
- Reset: assert rst 2 cycles -> busy=0, done=0, dut_in=0, tt_out=0, match=0, mismatch_cnt=0.
- Golden DUT (0xA2DA netlist), SETTLE_CYCLES=0, start -> dut_in steps 0..15 one per cycle. done pulses 17 cycles after start; tt_out=16'hA2DA, match=1, mismatch_cnt=0.
- dut_out tied 0 -> tt_out=16'h0000, match=0, mismatch_cnt=8, first_err_idx=0.
- SETTLE_CYCLES=2, golden DUT -> each dut_in value held 3 cycles, busy high 48 cycles, tt_out=16'hA2DA.
- Abort at cycle 5 after a completed golden sweep -> busy falls next cycle, no done, tt_out stays 16'hA2DA. start pulsed during busy has no effect on the timing of done.
- rst at cycle 8 of a sweep -> all outputs 0 next cycle. A new start then completes normally with tt_out=16'hA2DA.
